// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and encodings for the 5-stage core pipeline.
//               Provides the result-select encodings, the MEM-stage handshake
//               state type and the MEM/WB pipeline register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Result-select encodings, shared with the control unit and execute stage
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // Data-memory handshake state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus_4;
    logic [31:0] imm_ext;
  } memwb_t;

  // Write-back value selected from a MEM/WB entry
  function automatic logic [31:0] select_result(input memwb_t e);
    logic [31:0] r;
    case (e.result_src)
      RES_ALU: r = e.alu_result;
      RES_MEM: r = e.read_data;
      RES_PC4: r = e.pc_plus_4;
      RES_IMM: r = e.imm_ext;
      default: r = e.alu_result;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_handshake.sv
`default_nettype none
// ============================================================================
// Module      : dmem_handshake
// Description : Data-memory req/ack sequencer for the MEM stage. Issues the
//               request, stalls the pipeline while the access is outstanding
//               and aborts it after TIMEOUT wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_handshake
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  // 2**CNT_W must exceed TIMEOUT so the counter can reach the limit
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,      // synchronous, active-low
  input  logic start,      // aligned access presented in EX/MEM
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic done,       // access completed with an acknowledge
  output logic abort       // access given up after the timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, wait counter and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            // zero-wait access retires this cycle
            done = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_d   = WAIT;
            cnt_d     = CNT_ONE;
          end
        end
      end
      WAIT: begin
        // Upstream is stalled, so address/data/we stay stable here
        dmem_req = 1'b1;
        if (dmem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_C) begin
          // Drop the request and let the instruction retire with a fault
          dmem_req = 1'b0;
          abort    = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Nothing may leave the stage while reset is held
    if (!reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stage_memory.sv
`default_nettype none
// ============================================================================
// Module      : stage_memory
// Description : MEM stage of the 5-stage core. Drives the data-memory port,
//               stalls upstream while an access is outstanding, tracks
//               alignment/timeout faults and holds the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_memory
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,          // synchronous, active-low
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] mem_fault_addr,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_result
);

  logic        is_load;
  logic        is_access;
  logic        misaligned;
  logic        start;
  logic        hs_done;
  logic        hs_abort;
  logic        fault_event;

  memwb_t      memwb_q, memwb_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  // Classify the instruction sitting in EX/MEM
  always_comb begin
    is_load    = mem_reg_write & (mem_result_src == RES_MEM);
    is_access  = is_load | mem_mem_write;
    misaligned = is_access & (mem_alu_result[1:0] != 2'b00);
    start      = is_access & ~misaligned;
  end

  dmem_handshake #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .mem_stall (mem_stall),
    .done      (hs_done),
    .abort     (hs_abort)
  );

  // Memory port: address and data come straight from the held EX/MEM fields
  always_comb begin
    dmem_we    = dmem_req & mem_mem_write;
    dmem_addr  = mem_alu_result;
    dmem_wdata = mem_write_data;
  end

  // MEM/WB next value: flush and stall both insert a bubble, so an
  // instruction that waits on memory retires exactly once
  always_comb begin
    memwb_d = '0;
    if (!wb_clear && !mem_stall) begin
      memwb_d.reg_write  = mem_reg_write;
      memwb_d.rd         = mem_rd;
      memwb_d.result_src = mem_result_src;
      memwb_d.alu_result = mem_alu_result;
      // Aborted, misaligned and non-load instructions carry zero load data
      memwb_d.read_data  = (is_load && hs_done) ? dmem_rdata : 32'h0;
      memwb_d.pc_plus_4  = mem_pc_plus_4;
      memwb_d.imm_ext    = mem_imm_ext;
    end
  end

  // Sticky fault flag; the address is latched only for the first fault
  always_comb begin
    fault_event  = misaligned | hs_abort;
    fault_d      = fault_q | fault_event;
    fault_addr_d = fault_addr_q;
    if (fault_event && !fault_q) begin
      fault_addr_d = mem_alu_result;
    end
  end

  // MEM/WB and fault registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      memwb_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      memwb_q      <= memwb_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Outputs toward write-back, forwarding and the hazard unit
  always_comb begin
    wb_reg_write   = memwb_q.reg_write;
    wb_rd          = memwb_q.rd;
    wb_result      = select_result(memwb_q);
    mem_fault      = fault_q;
    mem_fault_addr = fault_addr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_memory
// Description : Self-checking bench for stage_memory. Directed scenarios
//               followed by random instructions checked against a
//               per-instruction latency/fault reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_memory;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_clear;
  logic        mem_reg_write;
  logic        mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [31:0] mem_pc_plus_4;
  logic [31:0] mem_imm_ext;
  logic [4:0]  mem_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        mem_fault;
  logic [31:0] mem_fault_addr;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;

  int          errors = 0;
  int          checks = 0;
  logic        exp_fault;
  logic [31:0] exp_fault_addr;

  always #5 clk = ~clk;

  stage_memory #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_clear       (wb_clear),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_write  (mem_mem_write),
    .mem_result_src (mem_result_src),
    .mem_alu_result (mem_alu_result),
    .mem_write_data (mem_write_data),
    .mem_pc_plus_4  (mem_pc_plus_4),
    .mem_imm_ext    (mem_imm_ext),
    .mem_rd         (mem_rd),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .mem_stall      (mem_stall),
    .mem_fault      (mem_fault),
    .mem_fault_addr (mem_fault_addr),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    wb_clear       = 1'b0;
    mem_reg_write  = 1'b0;
    mem_mem_write  = 1'b0;
    mem_result_src = 2'b00;
    mem_alu_result = 32'h0;
    mem_write_data = 32'h0;
    mem_pc_plus_4  = 32'h0;
    mem_imm_ext    = 32'h0;
    mem_rd         = 5'd0;
    dmem_rdata     = 32'h0;
    dmem_ack       = 1'b0;
  endtask

  // One instruction through MEM, held while stalled. The memory acknowledges
  // lat cycles after the request; lat > TIMEOUT means it never answers.
  // Called at posedge+1; returns at posedge+1 after the instruction retires.
  task automatic run_instr(input logic rw, input logic mw, input logic [1:0] src,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc4, input logic [31:0] imm,
                           input logic [4:0] rd, input int lat,
                           input logic [31:0] rdata, input logic flush);
    logic        ld, acc, mis, acc_ok, aborted, req_exp;
    int          exp_stall;
    logic [31:0] load_val, exp_res, r;
    ld      = rw && (src == 2'b01);
    acc     = ld || mw;
    mis     = acc && (alu[1:0] != 2'b00);
    acc_ok  = acc && !mis;
    aborted = acc_ok && (lat > TIMEOUT);
    if (!acc_ok)      exp_stall = 0;
    else if (aborted) exp_stall = TIMEOUT;
    else              exp_stall = lat;
    load_val = (ld && acc_ok && !aborted) ? rdata : 32'h0;
    case (src)
      2'b00:   exp_res = alu;
      2'b01:   exp_res = load_val;
      2'b10:   exp_res = pc4;
      default: exp_res = imm;
    endcase
    if (mis || aborted) begin
      if (!exp_fault) exp_fault_addr = alu;
      exp_fault = 1'b1;
    end

    mem_reg_write  = rw;
    mem_mem_write  = mw;
    mem_result_src = src;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_pc_plus_4  = pc4;
    mem_imm_ext    = imm;
    mem_rd         = rd;

    for (int k = 0; k <= exp_stall; k++) begin
      r          = $urandom;
      wb_clear   = (k < exp_stall) ? r[0] : flush;
      dmem_ack   = acc_ok && (k == lat);
      dmem_rdata = (acc_ok && (k == lat)) ? rdata : $urandom;
      req_exp    = acc_ok && !(aborted && (k == TIMEOUT));
      @(negedge clk);
      chk1("mem_stall", mem_stall, k < exp_stall);
      chk1("dmem_req", dmem_req, req_exp);
      if (req_exp) begin
        chk32("dmem_addr", dmem_addr, alu);
        chk32("dmem_wdata", dmem_wdata, wd);
        chk1("dmem_we", dmem_we, mw);
      end
      @(posedge clk);
      #1;
      if (k < exp_stall) chk1("wb_bubble", wb_reg_write, 1'b0);
    end
    dmem_ack = 1'b0;
    wb_clear = 1'b0;

    chk1("wb_reg_write", wb_reg_write, flush ? 1'b0 : rw);
    chk32("wb_rd", {27'd0, wb_rd}, flush ? 32'h0 : {27'd0, rd});
    chk32("wb_result", wb_result, flush ? 32'h0 : exp_res);
    chk1("mem_fault", mem_fault, exp_fault);
    chk32("mem_fault_addr", mem_fault_addr, exp_fault_addr);
  endtask

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, a;
    logic [1:0]  s;
    logic        rw, mw, fl;
    int          lat;

    exp_fault      = 1'b0;
    exp_fault_addr = 32'h0;

    // Reset with a load presented: nothing may be requested or stalled
    reset = 1'b0;
    drive_idle();
    mem_reg_write  = 1'b1;
    mem_result_src = 2'b01;
    mem_alu_result = 32'h80;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_wb_reg_write", wb_reg_write, 1'b0);
    chk32("rst_wb_rd", {27'd0, wb_rd}, 32'h0);
    chk32("rst_wb_result", wb_result, 32'h0);
    chk1("rst_fault", mem_fault, 1'b0);
    chk32("rst_fault_addr", mem_fault_addr, 32'h0);
    drive_idle();
    reset = 1'b1;

    // Zero-wait load
    run_instr(1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 32'h104, 32'h9, 5'd5, 0, 32'hDEADBEEF, 1'b0);
    // Store acknowledged three cycles after the request
    run_instr(1'b0, 1'b1, 2'b00, 32'h200, 32'h1234, 32'h208, 32'h0, 5'd0, 3, 32'h0, 1'b0);
    // ALU result, then a flushed instruction
    run_instr(1'b1, 1'b0, 2'b00, 32'h55, 32'h0, 32'h10, 32'h0, 5'd3, 0, 32'h0, 1'b0);
    run_instr(1'b1, 1'b0, 2'b00, 32'h77, 32'h0, 32'h14, 32'h0, 5'd4, 0, 32'h0, 1'b1);
    // pc+4 and immediate selects
    run_instr(1'b1, 1'b0, 2'b10, 32'h1, 32'h0, 32'h18, 32'h0, 5'd8, 0, 32'h0, 1'b0);
    run_instr(1'b1, 1'b0, 2'b11, 32'h1, 32'h0, 32'h1C, 32'hABC, 5'd9, 0, 32'h0, 1'b0);
    // Misaligned load: first fault, no request, writes 0
    run_instr(1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h20, 32'h0, 5'd6, 0, 32'hCAFE, 1'b0);
    // A second fault must not overwrite the captured address
    run_instr(1'b0, 1'b1, 2'b00, 32'h301, 32'h5, 32'h24, 32'h0, 5'd0, 0, 32'h0, 1'b0);

    // Reset asserted while a load is waiting
    mem_reg_write  = 1'b1;
    mem_mem_write  = 1'b0;
    mem_result_src = 2'b01;
    mem_alu_result = 32'h300;
    mem_rd         = 5'd7;
    dmem_ack       = 1'b0;
    @(negedge clk);
    chk1("wait_entry_stall", mem_stall, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_wait_req", dmem_req, 1'b0);
    chk1("rst_wait_stall", mem_stall, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_wait_fault", mem_fault, 1'b0);
    chk32("rst_wait_fault_addr", mem_fault_addr, 32'h0);
    chk1("rst_wait_wb_reg_write", wb_reg_write, 1'b0);
    exp_fault      = 1'b0;
    exp_fault_addr = 32'h0;
    drive_idle();
    reset = 1'b1;

    // Load that is never acknowledged: aborts after TIMEOUT stall cycles
    run_instr(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 32'h404, 32'h0, 5'd10, TIMEOUT + 1, 32'h0, 1'b0);
    // Ack exactly on the last permitted cycle still completes
    run_instr(1'b1, 1'b0, 2'b01, 32'h500, 32'h0, 32'h504, 32'h0, 5'd11, TIMEOUT, 32'h600DF00D, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      r   = $urandom;
      rw  = r[0];
      mw  = r[1];
      s   = r[3:2];
      fl  = (r[7:4] == 4'd0);
      a   = $urandom;
      if (r[9:8] != 2'b00) a[1:0] = 2'b00;
      lat = $urandom_range(0, TIMEOUT + 1);
      run_instr(rw, mw, s, a, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                lat, $urandom, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- MEM stage of the 5-stage core; consumes the EX/MEM pipeline register produced by the execute stage.
- Drives the data-memory port with a req/ack handshake that supports multi-cycle latency, and stalls upstream stages while an access is outstanding.
- Registers the MEM/WB pipeline register and produces the combinational wb_result, which is forwarded back to the execute stage and the hazard unit.

Parameters:
- TIMEOUT, 255: max cycles waiting in WAIT before the access is aborted as a fault.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
- wb_clear  in  1  flush; MEM/WB register loads a bubble.
- mem_reg_write  in  1  instruction writes the register file.
- mem_mem_write  in  1  store.
- mem_result_src  in  2  result select: 00 alu, 01 load data, 10 pc+4, 11 imm.
- mem_alu_result  in  32  effective address or ALU value.
- mem_write_data  in  32  store data.
- mem_pc_plus_4  in  32  pc+4.
- mem_imm_ext  in  32  immediate.
- mem_rd  in  5  destination register.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address (byte address, [1:0]=00).
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data; valid when dmem_ack=1.
- dmem_ack  in  1  access complete.
- mem_stall  out  1  to hazard unit; holds PC, IF/ID, ID/EX and EX/MEM.
- mem_fault  out  1  sticky fault flag.
- mem_fault_addr  out  32  address of the first fault.
- wb_reg_write  out  1  MEM/WB register output.
- wb_rd  out  5  MEM/WB register output.
- wb_result  out  32  combinational mux of the MEM/WB fields by wb_result_src.

Behaviour:
- Definitions: load = mem_reg_write & (mem_result_src==01); access = load | mem_mem_write; misaligned = access & (mem_alu_result[1:0]!=0).
- Internal MEM/WB fields: wb_result_src[1:0], wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext.
- Reset (reset==0):
  - state=IDLE, counter=0.
  - All MEM/WB fields 0, wb_reg_write=0, wb_rd=0.
  - mem_fault=0, mem_fault_addr=0.
  - dmem_req and mem_stall forced to 0 combinationally while reset==0.
- FSM state IDLE:
  - access & !misaligned -> dmem_req=1 the same cycle; dmem_we=mem_mem_write; dmem_addr=mem_alu_result; dmem_wdata=mem_write_data.
  - dmem_ack=1 in the same cycle -> zero-wait completion, no stall.
  - dmem_ack=0 -> mem_stall=1, next state WAIT, counter=1.
- FSM state WAIT:
  - dmem_req stays 1; address, data and we stay stable (inputs are held by the stall).
  - dmem_ack=1 -> completion, mem_stall=0, next state IDLE.
  - counter==TIMEOUT with no ack -> abort: mem_stall=0, dmem_req=0, complete with read data 0, set the fault, next state IDLE.
  - Otherwise counter+1, mem_stall=1.
- Misaligned access: no request issued, completes immediately, sets the fault. A misaligned load writes 0; a misaligned store is dropped.
- Fault: mem_fault is set and stays 1 until reset. mem_fault_addr captures only the first faulting address.
- MEM/WB register, priority reset > wb_clear > mem_stall > normal:
  - wb_clear: load a bubble (wb_reg_write=0, all fields 0).
  - mem_stall=1: load a bubble, so the instruction retires exactly once.
  - Normal: capture the inputs; wb_read_data = dmem_rdata on ack, 0 on abort/misaligned/non-load.
- wb_clear during WAIT: has no effect on the FSM. The outstanding access completes normally and is never cancelled mid-handshake.
- Latency: 1 cycle to WB on zero-wait access; N+1 cycles when ack arrives N cycles after request.
- Non-access instructions: pass through in 1 cycle; dmem_req=0.

Decomposition:
- Shared package core_pkg:
  - result_src encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11 (also used by control unit and execute stage).
  - mem_state_t enum {IDLE, WAIT}.
- Sub-module dmem_handshake: FSM, wait counter and timeout. Outputs dmem_req, mem_stall, done and abort; stage_memory keeps the pipeline register and fault logic.

Test Plan:
- Load (result_src=01, rd=5, addr 0x100), ack same cycle with rdata 0xDEADBEEF -> no stall; next cycle wb_reg_write=1, wb_rd=5, wb_result=0xDEADBEEF.
- Store (addr 0x200, data 0x1234), ack after 3 cycles:
  - mem_stall=1 for exactly 3 cycles; dmem_addr/wdata stable; dmem_we=1.
  - WB gets bubbles during the stall, then one entry with wb_reg_write=0.
- Load with no ack, TIMEOUT=4 -> stall 4 cycles then release; wb_result=0; mem_fault=1; mem_fault_addr=the load address.
- Misaligned load addr 0x102 -> dmem_req never 1; no stall; mem_fault=1, mem_fault_addr=0x102; wb_result=0.
- reset=0 during WAIT -> next cycle state IDLE, dmem_req=0, mem_stall=0, mem_fault=0, wb_reg_write=0.
- ALU instruction (result_src=00, alu 0x55) followed by wb_clear=1 on the next one -> first gives wb_result=0x55; flushed one gives wb_reg_write=0.
